// File: rtl/datapath_ctrl_pkg.sv
// Shared definitions for the ALU datapath sequencer and the datapath it drives.
// Contents: FSM state encoding, operand-mux select codes, source-mode codes,
// command-word field positions and the default opcode geometry.
package datapath_ctrl_pkg;

  localparam int OP_W_DEF    = 4;
  localparam int NUM_OPS_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EXEC = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Operand mux select codes (mux A uses SEL_FB for dout_high, mux B for dout_low)
  localparam logic [1:0] SEL_DIN1 = 2'd0;
  localparam logic [1:0] SEL_DIN2 = 2'd1;
  localparam logic [1:0] SEL_DIN3 = 2'd2;
  localparam logic [1:0] SEL_FB   = 2'd3;

  // Source modes carried in the low bits of the command word
  localparam logic [1:0] MODE_D1_D2 = 2'd0;
  localparam logic [1:0] MODE_D1_D3 = 2'd1;
  localparam logic [1:0] MODE_D2_D3 = 2'd2;
  localparam logic [1:0] MODE_ACC   = 2'd3;

  // Command word layout: {opcode, mode}
  localparam int CMD_MODE_LSB = 0;
  localparam int CMD_MODE_W   = 2;
  localparam int CMD_OP_LSB   = 2;

endpackage

// File: rtl/datapath_ctrl_cmd_decode.sv
// Combinational decode of the registered command word.
// Ports:
//   cmd_dec  in   registered command {opcode, mode}
//   sel_a    out  operand A mux select for the command's source mode
//   sel_b    out  operand B mux select for the command's source mode
//   opcode   out  opcode field
//   op_legal out  1 when opcode < NUM_OPS
module ctrl_cmd_decode
  import datapath_ctrl_pkg::*;
#(
  parameter int OP_W    = OP_W_DEF,
  parameter int NUM_OPS = NUM_OPS_DEF
) (
  input  logic [OP_W+1:0] cmd_dec,
  output logic [1:0]      sel_a,
  output logic [1:0]      sel_b,
  output logic [OP_W-1:0] opcode,
  output logic            op_legal
);

  logic [CMD_MODE_W-1:0] mode;

  always_comb begin
    mode     = cmd_dec[CMD_MODE_LSB +: CMD_MODE_W];
    opcode   = cmd_dec[CMD_OP_LSB +: OP_W];
    op_legal = (32'(opcode) < 32'(NUM_OPS));
    sel_a    = SEL_DIN1;
    sel_b    = SEL_DIN2;
    case (mode)
      MODE_D1_D2: begin sel_a = SEL_DIN1; sel_b = SEL_DIN2; end
      MODE_D1_D3: begin sel_a = SEL_DIN1; sel_b = SEL_DIN3; end
      MODE_D2_D3: begin sel_a = SEL_DIN2; sel_b = SEL_DIN3; end
      MODE_ACC:   begin sel_a = SEL_FB;   sel_b = SEL_FB;   end
      default:    begin sel_a = SEL_DIN1; sel_b = SEL_DIN2; end
    endcase
  end

endmodule

// File: rtl/datapath_ctrl.sv
// Sequencing FSM for the 8-bit ALU datapath: one command per start handshake,
// issuing command load, operand load, ALU execute and result load in turn.
//
// state | meaning
// IDLE  | waiting; start loads the command register this cycle
// LOAD  | command valid; select operands, load ALU input registers
// EXEC  | drive opcode; load result unless the opcode is illegal
// DONE  | done pulse; start here is accepted back-to-back
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start / ready            command handshake (accepted when both high)
//   cmd_dec                  registered command read back from the datapath
//   busy, done, illegal      status
//   datain_reg_en, aluin_reg_en, aluout_reg_en   datapath load enables
//   in_select_a/b, opcode, nvalid_data           datapath control
module datapath_ctrl
  import datapath_ctrl_pkg::*;
#(
  parameter int OP_W    = OP_W_DEF,
  parameter int NUM_OPS = NUM_OPS_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [OP_W+1:0] cmd_dec,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic            illegal,
  output logic            datain_reg_en,
  output logic            aluin_reg_en,
  output logic [1:0]      in_select_a,
  output logic [1:0]      in_select_b,
  output logic [OP_W-1:0] opcode,
  output logic            nvalid_data,
  output logic            aluout_reg_en
);

  state_e          state_q, state_d;
  logic            illegal_q, illegal_d;
  logic [1:0]      sel_a_q, sel_b_q;
  logic [OP_W-1:0] opcode_q;

  logic [1:0]      dec_sel_a, dec_sel_b;
  logic [OP_W-1:0] dec_opcode;
  logic            dec_legal;

  ctrl_cmd_decode #(
    .OP_W    (OP_W),
    .NUM_OPS (NUM_OPS)
  ) u_decode (
    .cmd_dec  (cmd_dec),
    .sel_a    (dec_sel_a),
    .sel_b    (dec_sel_b),
    .opcode   (dec_opcode),
    .op_legal (dec_legal)
  );

  // Selects and opcode are remembered so they hold outside LOAD/EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      illegal_q <= 1'b0;
      sel_a_q   <= '0;
      sel_b_q   <= '0;
      opcode_q  <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      if (state_q == ST_LOAD) begin
        sel_a_q <= dec_sel_a;
        sel_b_q <= dec_sel_b;
      end
      if (state_q == ST_EXEC) begin
        opcode_q <= dec_opcode;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    illegal_d     = illegal_q;
    ready         = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    illegal       = 1'b0;
    datain_reg_en = 1'b0;
    aluin_reg_en  = 1'b0;
    aluout_reg_en = 1'b0;
    nvalid_data   = 1'b1;
    in_select_a   = sel_a_q;
    in_select_b   = sel_b_q;
    opcode        = opcode_q;

    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) begin
          datain_reg_en = 1'b1;
          state_d       = ST_LOAD;
        end
      end
      ST_LOAD: begin
        busy         = 1'b1;
        in_select_a  = dec_sel_a;
        in_select_b  = dec_sel_b;
        aluin_reg_en = 1'b1;
        state_d      = ST_EXEC;
      end
      ST_EXEC: begin
        busy      = 1'b1;
        opcode    = dec_opcode;
        illegal_d = ~dec_legal;
        if (dec_legal) begin
          nvalid_data   = 1'b0;
          aluout_reg_en = 1'b1;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        illegal = illegal_q;
        ready   = 1'b1;
        if (start) begin
          datain_reg_en = 1'b1;
          state_d       = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A command caught by reset must not commit anything in that cycle.
    if (rst) begin
      datain_reg_en = 1'b0;
      aluin_reg_en  = 1'b0;
      aluout_reg_en = 1'b0;
      nvalid_data   = 1'b1;
    end
  end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl with a small behavioural 8-bit datapath beside it.
module tb_datapath_ctrl;
  import datapath_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [5:0] cmdin;
  logic [7:0] din_1, din_2, din_3;

  logic       ready, busy, done, illegal;
  logic       datain_reg_en, aluin_reg_en, aluout_reg_en, nvalid_data;
  logic [1:0] in_select_a, in_select_b;
  logic [3:0] opcode;

  logic [5:0] cmd_q;
  logic [7:0] a_q, b_q, dout_high, dout_low, mux_a, mux_b;
  logic       zero_q;
  logic [15:0] alu_res;
  logic [7:0] ctl;

  int checks = 0;
  int errors = 0;

  datapath_ctrl #(.OP_W(4), .NUM_OPS(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cmd_dec       (cmd_q),
    .ready         (ready),
    .busy          (busy),
    .done          (done),
    .illegal       (illegal),
    .datain_reg_en (datain_reg_en),
    .aluin_reg_en  (aluin_reg_en),
    .in_select_a   (in_select_a),
    .in_select_b   (in_select_b),
    .opcode        (opcode),
    .nvalid_data   (nvalid_data),
    .aluout_reg_en (aluout_reg_en)
  );

  always #5 clk = ~clk;

  // {datain, aluin, aluout, done, illegal, busy, ready, nvalid}
  assign ctl = {datain_reg_en, aluin_reg_en, aluout_reg_en, done, illegal, busy, ready, nvalid_data};

  function automatic logic [15:0] alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd0: alu = 16'(a) + 16'(b);
      4'd1: alu = 16'(a) - 16'(b);
      4'd2: alu = {8'h00, a & b};
      4'd3: alu = {8'h00, a | b};
      4'd4: alu = {8'h00, a ^ b};
      4'd5: alu = 16'(a) * 16'(b);
      4'd6: alu = {7'b0, a, 1'b0};
      4'd7: alu = {8'h00, a >> 1};
      default: alu = 16'h0000;
    endcase
  endfunction

  always_comb begin
    mux_a = din_1;
    mux_b = din_2;
    case (in_select_a)
      2'd0: mux_a = din_1;
      2'd1: mux_a = din_2;
      2'd2: mux_a = din_3;
      default: mux_a = dout_high;
    endcase
    case (in_select_b)
      2'd0: mux_b = din_1;
      2'd1: mux_b = din_2;
      2'd2: mux_b = din_3;
      default: mux_b = dout_low;
    endcase
    alu_res = alu(opcode, a_q, b_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q <= '0; a_q <= '0; b_q <= '0;
      dout_high <= '0; dout_low <= '0; zero_q <= 1'b0;
    end else begin
      if (datain_reg_en) cmd_q <= cmdin;
      if (aluin_reg_en) begin a_q <= mux_a; b_q <= mux_b; end
      if (aluout_reg_en && !nvalid_data) begin
        {dout_high, dout_low} <= alu_res;
        zero_q <= (alu_res == 16'h0000);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cmdin = '0; din_1 = '0; din_2 = '0; din_3 = '0;
    tick(); tick();
    rst = 1'b0; #1;
    checks++;
    if (ctl !== 8'b0000_0011) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 8'b0000_0011); end
    checks++;
    if ({opcode, in_select_a, in_select_b} !== 8'h00) begin errors++; $display("FAIL reset_op_sel got=%h exp=00", {opcode, in_select_a, in_select_b}); end
    checks++;
    if ({dout_high, dout_low} !== 16'h0000) begin errors++; $display("FAIL reset_dout got=%h exp=0000", {dout_high, dout_low}); end
  endtask

  task automatic test_add();
    din_1 = 8'd5; din_2 = 8'd3; din_3 = 8'd0;
    cmdin = {4'd0, MODE_D1_D2}; start = 1'b1; #1;
    checks++;
    if (ctl !== 8'b1000_0011) begin errors++; $display("FAIL add_c0 got=%b exp=%b", ctl, 8'b1000_0011); end
    tick(); cmdin = 6'h3F; #1;   // start kept high while busy: must be ignored
    checks++;
    if (ctl !== 8'b0100_0101) begin errors++; $display("FAIL add_c1 got=%b exp=%b", ctl, 8'b0100_0101); end
    checks++;
    if ({in_select_a, in_select_b} !== 4'b0001) begin errors++; $display("FAIL add_sel got=%b exp=0001", {in_select_a, in_select_b}); end
    tick(); #1;
    checks++;
    if (ctl !== 8'b0010_0100 || opcode !== 4'd0) begin errors++; $display("FAIL add_c2 got=%b/%0d exp=%b/0", ctl, opcode, 8'b0010_0100); end
    tick(); start = 1'b0; #1;
    checks++;
    if (ctl !== 8'b0001_0011) begin errors++; $display("FAIL add_c3 got=%b exp=%b", ctl, 8'b0001_0011); end
    checks++;
    if ({dout_high, dout_low} !== 16'd8 || zero_q !== 1'b0) begin errors++; $display("FAIL add_dout got=%h z=%b exp=0008 z=0", {dout_high, dout_low}, zero_q); end
    tick(); #1;
    checks++;
    if (ctl !== 8'b0000_0011) begin errors++; $display("FAIL add_idle got=%b exp=%b", ctl, 8'b0000_0011); end
  endtask

  task automatic test_accumulate();
    cmdin = {4'd0, MODE_ACC}; start = 1'b1; #1;
    tick(); start = 1'b0; #1;
    checks++;
    if ({in_select_a, in_select_b} !== 4'b1111 || aluin_reg_en !== 1'b1) begin errors++; $display("FAIL acc_sel got=%b en=%b exp=1111 en=1", {in_select_a, in_select_b}, aluin_reg_en); end
    tick(); tick(); #1;
    checks++;
    if (done !== 1'b1 || {dout_high, dout_low} !== 16'd8 || zero_q !== 1'b0) begin errors++; $display("FAIL acc_dout got=%h done=%b z=%b exp=0008 1 0", {dout_high, dout_low}, done, zero_q); end
    tick();
  endtask

  task automatic test_modes();
    logic [5:0]  v_cmd  [3];
    logic [23:0] v_din  [3];
    logic [3:0]  v_sel  [3];
    logic [15:0] v_dout [3];
    v_cmd[0] = {4'd5, MODE_D2_D3}; v_din[0] = {8'd0, 8'd3, 8'd7};    v_sel[0] = 4'b0110; v_dout[0] = 16'd21;
    v_cmd[1] = {4'd1, MODE_D1_D3}; v_din[1] = {8'd5, 8'd0, 8'd7};    v_sel[1] = 4'b0010; v_dout[1] = 16'hFFFE;
    v_cmd[2] = {4'd7, MODE_D1_D2}; v_din[2] = {8'h80, 8'd1, 8'd0};   v_sel[2] = 4'b0001; v_dout[2] = 16'h0040;
    for (int i = 0; i < 3; i++) begin
      {din_1, din_2, din_3} = v_din[i];
      cmdin = v_cmd[i]; start = 1'b1; #1;
      tick(); start = 1'b0; #1;
      checks++;
      if ({in_select_a, in_select_b} !== v_sel[i]) begin errors++; $display("FAIL mode%0d_sel got=%b exp=%b", i, {in_select_a, in_select_b}, v_sel[i]); end
      tick(); #1;
      checks++;
      if (aluout_reg_en !== 1'b1 || opcode !== v_cmd[i][5:2]) begin errors++; $display("FAIL mode%0d_exec en=%b op=%0d exp en=1 op=%0d", i, aluout_reg_en, opcode, v_cmd[i][5:2]); end
      tick(); #1;
      checks++;
      if ({dout_high, dout_low} !== v_dout[i] || done !== 1'b1) begin errors++; $display("FAIL mode%0d_dout got=%h done=%b exp=%h", i, {dout_high, dout_low}, done, v_dout[i]); end
      tick(); #1;
    end
    checks++;
    if (opcode !== 4'd7 || {in_select_a, in_select_b} !== 4'b0001) begin errors++; $display("FAIL hold_idle op=%0d sel=%b exp op=7 sel=0001", opcode, {in_select_a, in_select_b}); end
  endtask

  task automatic test_illegal();
    logic [3:0] ops [2];
    ops[0] = 4'd12; ops[1] = 4'd8;
    for (int i = 0; i < 2; i++) begin
      din_1 = 8'd9; din_2 = 8'd9;
      cmdin = {ops[i], MODE_D1_D2}; start = 1'b1; #1;
      tick(); start = 1'b0; #1;
      checks++;
      if (ctl !== 8'b0100_0101) begin errors++; $display("FAIL ill%0d_c1 got=%b exp=%b", i, ctl, 8'b0100_0101); end
      tick(); #1;
      checks++;
      if (ctl !== 8'b0000_0101 || opcode !== ops[i]) begin errors++; $display("FAIL ill%0d_c2 got=%b op=%0d exp=%b op=%0d", i, ctl, opcode, 8'b0000_0101, ops[i]); end
      tick(); #1;
      checks++;
      if (ctl !== 8'b0001_1011) begin errors++; $display("FAIL ill%0d_c3 got=%b exp=%b", i, ctl, 8'b0001_1011); end
      checks++;
      if ({dout_high, dout_low} !== 16'h0040) begin errors++; $display("FAIL ill%0d_dout got=%h exp=0040", i, {dout_high, dout_low}); end
      tick(); #1;
    end
  endtask

  task automatic test_back_to_back();
    int n_done = 0, n_load = 0, n_out = 0, n_ill = 0, n_bad = 0;
    din_1 = 8'd1; din_2 = 8'd2;
    cmdin = {4'd0, MODE_D1_D2};
    for (int i = 0; i < 12; i++) begin
      start = (i < 9); #1;
      if (done) n_done++;
      if (datain_reg_en) n_load++;
      if (aluout_reg_en) n_out++;
      if (illegal) n_ill++;
      if ((busy && done) || (int'(datain_reg_en) + int'(aluin_reg_en) + int'(aluout_reg_en) > 1)
          || (datain_reg_en && !ready)) n_bad++;
      tick();
    end
    start = 1'b0;
    checks++;
    if (n_done !== 3) begin errors++; $display("FAIL b2b_done got=%0d exp=3", n_done); end
    checks++;
    if (n_load !== 3 || n_out !== 3) begin errors++; $display("FAIL b2b_enables load=%0d out=%0d exp=3/3", n_load, n_out); end
    checks++;
    if (n_ill !== 0 || n_bad !== 0) begin errors++; $display("FAIL b2b_rules ill=%0d bad=%0d exp=0/0", n_ill, n_bad); end
    checks++;
    if ({dout_high, dout_low} !== 16'd3) begin errors++; $display("FAIL b2b_dout got=%h exp=0003", {dout_high, dout_low}); end
  endtask

  task automatic test_reset_mid_op();
    rst = 1'b1; tick(); rst = 1'b0;
    din_1 = 8'd5; din_2 = 8'd3;
    cmdin = {4'd0, MODE_D1_D2}; start = 1'b1; #1;
    tick(); start = 1'b0; #1;
    tick();                     // now in EXEC
    rst = 1'b1; #1;
    checks++;
    if (aluout_reg_en !== 1'b0 || nvalid_data !== 1'b1) begin errors++; $display("FAIL rst_exec en=%b nv=%b exp=0/1", aluout_reg_en, nvalid_data); end
    tick(); #1;
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_idle r=%b b=%b d=%b exp=1/0/0", ready, busy, done); end
    rst = 1'b0;
    tick(); #1;
    checks++;
    if ({dout_high, dout_low} !== 16'h0000 || ctl !== 8'b0000_0011) begin errors++; $display("FAIL rst_after dout=%h ctl=%b exp=0000 %b", {dout_high, dout_low}, ctl, 8'b0000_0011); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_accumulate();
    test_modes();
    test_illegal();
    test_back_to_back();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
